// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX-stage operand forwarding selects, load-use stall and stall counter
module fwd_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [RA_W-1:0]  ex_rs,
  input  logic [RA_W-1:0]  ex_rt,
  input  logic             ex_uses_rt,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_M  = 2'b01;
  localparam logic [1:0] SEL_W  = 2'b10;

  logic [RA_W-1:0]  m_rd_q, m_rd_d, w_rd_q;
  logic             m_wr_q, m_wr_d, m_ld_q, m_ld_d, w_wr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_m_a, hit_m_b, hit_w_a, hit_w_b;

  // Register $0 is hardwired to zero, so a write to it never produces a forwardable value.
  function automatic logic hit(input logic wr, input logic [RA_W-1:0] rd,
                               input logic [RA_W-1:0] src);
    return wr && (rd != '0) && (rd == src);
  endfunction

  always_comb begin
    hit_m_a = hit(m_wr_q, m_rd_q, ex_rs);
    hit_m_b = hit(m_wr_q, m_rd_q, ex_rt);
    hit_w_a = hit(w_wr_q, w_rd_q, ex_rs);
    hit_w_b = hit(w_wr_q, w_rd_q, ex_rt);
    stall   = ex_valid && m_ld_q && (hit_m_a || (ex_uses_rt && hit_m_b));

    fwd_a = SEL_RF;
    fwd_b = SEL_RF;
    if (ex_valid && !stall) begin
      if (hit_m_a)      fwd_a = SEL_M;
      else if (hit_w_a) fwd_a = SEL_W;
      if (ex_uses_rt) begin
        if (hit_m_b)      fwd_b = SEL_M;
        else if (hit_w_b) fwd_b = SEL_W;
      end
    end
  end

  always_comb begin
    m_rd_d = ex_rd;
    m_wr_d = ex_valid && ex_reg_write && !flush;
    m_ld_d = ex_valid && ex_mem_read && !flush;
    // A stall injects a bubble into MEM; the EX instruction is re-presented next cycle.
    if (stall) begin
      m_rd_d = m_rd_q;
      m_wr_d = 1'b0;
      m_ld_d = 1'b0;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rd_q <= '0;
      m_wr_q <= 1'b0;
      m_ld_q <= 1'b0;
      w_rd_q <= '0;
      w_wr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      m_rd_q <= m_rd_d;
      m_wr_q <= m_wr_d;
      m_ld_q <= m_ld_d;
      w_rd_q <= m_rd_q;
      w_wr_q <= m_wr_q;
      cnt_q  <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule
